// File: rtl/vip_edge_detect.sv
// vip_edge_detect: RGB565 to luma, 3x3 Sobel/Prewitt gradient, threshold.
// Six-stage pipeline; the sync signals travel through a matching delay line.
module vip_edge_detect #(
  parameter int H_MAX       = 1280,
  parameter int KERNEL      = 0,
  parameter int THRESH_INIT = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [15:0] pre_rgb,
  input  logic [7:0]  cfg_threshold,
  input  logic [1:0]  cfg_mode,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [15:0] post_rgb
);
  localparam int CW = $clog2(H_MAX + 1);
  localparam int AW = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam logic [CW-1:0] CMAX = CW'(H_MAX);
  localparam logic [10:0] WC = (KERNEL == 0) ? 11'd2 : 11'd1;

  logic [7:0]    w_r8, w_g8, w_b8;
  logic [15:0]   w_ysum;
  logic [7:0]    w_y;
  logic          w_vs_rise, w_de_fall;
  logic          w_bord, w_we;
  logic [AW-1:0] w_addr;
  logic [10:0]   w_ax, w_ay, w_msum;
  logic [5:0]    w_s6;
  logic [15:0]   w_res;

  logic [CW-1:0]    r_col;
  logic [1:0]       r_line;
  logic             r_vs_prev, r_de_prev;
  logic [7:0]       r_thr;
  logic [1:0]       r_mode;
  logic [5:0][2:0]  r_sync;
  logic [4:0][15:0] r_rgb;
  logic [7:0]       r_lb0 [H_MAX];
  logic [7:0]       r_lb1 [H_MAX];

  logic [7:0]    r1_y;
  logic [AW-1:0] r1_addr;
  logic          r1_we, r1_bord;
  logic [7:0]    r2_t, r2_m, r2_b;
  logic          r2_bord;
  logic [23:0]   r3_c0, r3_c1, r3_c2;
  logic          r3_bord;
  logic [10:0]   r4_gx, r4_gy;
  logic          r4_bord;
  logic [10:0]   r5_m;
  logic          r5_edge;
  logic [15:0]   r_out;

  function automatic logic [10:0] wsum(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return 11'(a) + WC * 11'(b) + 11'(c);
  endfunction

  assign w_r8 = {pre_rgb[15:11], pre_rgb[15:13]};
  assign w_g8 = {pre_rgb[10:5], pre_rgb[10:9]};
  assign w_b8 = {pre_rgb[4:0], pre_rgb[4:2]};
  assign w_ysum = 16'd77 * 16'(w_r8)
                + 16'd150 * 16'(w_g8)
                + 16'd29 * 16'(w_b8);
  assign w_y = 8'(w_ysum >> 8);

  assign w_vs_rise = pre_frame_vsync && !r_vs_prev;
  assign w_de_fall = !pre_frame_de && r_de_prev;
  assign w_bord = (r_line < 2'd2)
               || (r_col < CW'(2))
               || (r_col >= CMAX);
  assign w_we = pre_frame_de && (r_col < CMAX);
  assign w_addr = (r_col < CMAX) ? AW'(r_col) : '0;

  assign w_ax = r4_gx[10] ? 11'(-r4_gx) : r4_gx;
  assign w_ay = r4_gy[10] ? 11'(-r4_gy) : r4_gy;
  assign w_msum = w_ax + w_ay;

  always_comb begin
    w_s6 = (r5_m > 11'd255) ? 6'h3F : r5_m[7:2];
    w_res = 16'h0000;
    case (r_mode)
      2'd0:    w_res = r5_edge ? 16'h0000 : 16'hFFFF;
      2'd1:    w_res = r5_edge ? 16'hFFFF : 16'h0000;
      2'd2:    w_res = {w_s6[5:1], w_s6, w_s6[5:1]};
      default: w_res = r5_edge ? 16'hF800 : r_rgb[4];
    endcase
  end

  // Cascaded line buffers: lb0 holds line-1, lb1 holds line-2.
  always_ff @(posedge clk) begin
    if (r1_we) begin
      r_lb0[r1_addr] <= r1_y;
      r_lb1[r1_addr] <= r_lb0[r1_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_line    <= '0;
      r_vs_prev <= 1'b0;
      r_de_prev <= 1'b0;
      r_thr     <= 8'(THRESH_INIT);
      r_mode    <= '0;
      r_sync    <= '0;
      r_rgb     <= '0;
      r1_y      <= '0;
      r1_addr   <= '0;
      r1_we     <= 1'b0;
      r1_bord   <= 1'b1;
      r2_t      <= '0;
      r2_m      <= '0;
      r2_b      <= '0;
      r2_bord   <= 1'b1;
      r3_c0     <= '0;
      r3_c1     <= '0;
      r3_c2     <= '0;
      r3_bord   <= 1'b1;
      r4_gx     <= '0;
      r4_gy     <= '0;
      r4_bord   <= 1'b1;
      r5_m      <= '0;
      r5_edge   <= 1'b0;
      r_out     <= '0;
    end else begin
      r_vs_prev <= pre_frame_vsync;
      r_de_prev <= pre_frame_de;
      if (w_vs_rise) begin
        r_thr  <= cfg_threshold;
        r_mode <= cfg_mode;
      end
      if (pre_frame_de)
        r_col <= (r_col == CMAX) ? CMAX : r_col + 1'b1;
      else if (w_de_fall)
        r_col <= '0;
      if (w_vs_rise)
        r_line <= '0;
      else if (w_de_fall && r_line != 2'd3)
        r_line <= r_line + 2'd1;
      r_sync <= {r_sync[4:0],
                 {pre_frame_vsync, pre_frame_hsync, pre_frame_de}};
      r_rgb  <= {r_rgb[3:0], pre_rgb};
      r1_y    <= w_y;
      r1_addr <= w_addr;
      r1_we   <= w_we;
      r1_bord <= w_bord;
      r2_t    <= r_lb1[r1_addr];
      r2_m    <= r_lb0[r1_addr];
      r2_b    <= r1_y;
      r2_bord <= r1_bord;
      // Window columns: c0 = current, c1 = one back, c2 = two back.
      r3_c0   <= {r2_t, r2_m, r2_b};
      r3_c1   <= r3_c0;
      r3_c2   <= r3_c1;
      r3_bord <= r2_bord;
      r4_gx <= wsum(r3_c0[23:16], r3_c0[15:8], r3_c0[7:0])
             - wsum(r3_c2[23:16], r3_c2[15:8], r3_c2[7:0]);
      r4_gy <= wsum(r3_c2[7:0], r3_c1[7:0], r3_c0[7:0])
             - wsum(r3_c2[23:16], r3_c1[23:16], r3_c0[23:16]);
      r4_bord <= r3_bord;
      r5_m    <= r4_bord ? '0 : w_msum;
      r5_edge <= !r4_bord && (w_msum > {3'b000, r_thr});
      r_out   <= r_sync[4][0] ? w_res : 16'h0000;
    end
  end

  assign post_frame_vsync = r_sync[5][2];
  assign post_frame_hsync = r_sync[5][1];
  assign post_frame_de    = r_sync[5][0];
  assign post_rgb         = r_out;
endmodule

// File: doc/vip_edge_detect.md
VIP_EDGE_DETECT -- requirements
Module: vip_edge_detect

Interface
REQ-001 SHALL have parameter H_MAX, default 1280, meaning line-buffer depth (max active pixels per line).
REQ-002 SHALL have parameter KERNEL, default 0, meaning 0 = Sobel (weights 1,2,1), 1 = Prewitt (weights 1,1,1).
REQ-003 SHALL have parameter THRESH_INIT, default 128, meaning the threshold used until the first vsync latch.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports pre_frame_vsync / pre_frame_hsync / pre_frame_de  input  1 each  input frame sync, line sync, data enable.
REQ-007 SHALL have port pre_rgb  input  16  RGB565 pixel, valid when pre_frame_de=1.
REQ-008 SHALL have port cfg_threshold  input  8  edge threshold.
REQ-009 SHALL have port cfg_mode  input  2  output mode (see REQ-022).
REQ-010 SHALL have ports post_frame_vsync / post_frame_hsync / post_frame_de  output  1 each  delayed sync and enable.
REQ-011 SHALL have port post_rgb  output  16  RGB565 result.

Function
REQ-012 SHALL expand channels as R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]} and compute Y=(77*R8+150*G8+29*B8)>>8, 8-bit unsigned.
REQ-013 SHALL keep a column counter: +1 per de cycle, cleared on de falling edge, saturating at H_MAX.
REQ-014 SHALL keep a line counter: +1 on each de falling edge, cleared on the vsync rising edge, saturating at 3.
REQ-015 SHALL store Y in two line buffers of depth H_MAX addressed by column; writes SHALL be suppressed when column >= H_MAX.
REQ-016 SHALL form a 3x3 window with the current pixel at bottom-right: rows line-2, line-1, line; columns c-2..c.
REQ-017 SHALL compute Gx = right column minus left column and Gy = bottom row minus top row, both with KERNEL weights, signed 11-bit.
REQ-018 SHALL compute M = |Gx|+|Gy| as 11-bit unsigned; edge = (M > threshold).
REQ-019 SHALL force edge=0 and M=0 for line < 2, column < 2, or column >= H_MAX.
REQ-020 SHALL have a fixed latency of 6 clk from pre_* to post_*; vsync, hsync and de SHALL be delayed by the same 6 stages.
REQ-021 SHALL latch cfg_threshold and cfg_mode on the pre_frame_vsync rising edge only; mid-frame changes take effect at the next frame.
REQ-022 SHALL output while post_frame_de=1:
  - mode 0: edge ? 16'h0000 : 16'hFFFF
  - mode 1: edge ? 16'hFFFF : 16'h0000
  - mode 2: magnitude, S = min(M,255), output {S[7:3],S[7:2],S[7:3]}
  - mode 3: overlay, edge ? 16'hF800 : source pixel delayed 6 clk
REQ-023 SHALL drive post_rgb=16'h0000 whenever post_frame_de=0.
REQ-024 SHALL accept back-to-back de with no stall; a line shorter than a previous line SHALL not corrupt later lines.

Reset
REQ-025 SHALL, while rst_n=0, drive all post_* outputs to 0; counters, pipeline and sync delay stages to 0; threshold latch to THRESH_INIT; mode latch to 0.
REQ-026 SHALL, after reset is asserted mid-frame, treat the next line as line 0 (border-forced) until a vsync rising edge.
REQ-027 SHALL leave line-buffer contents unreset; the border rule in REQ-019 masks stale data.

Verification
REQ-028 SHALL pass: flat frame, all pixels 16'h7BEF, mode 0 -> every post_rgb = 16'hFFFF, post_frame_de exactly 6 clk after pre_frame_de.
REQ-029 SHALL pass: vertical step, cols 0-9 = 16'h0000, cols >= 10 = 16'hFFFF, Sobel, threshold 128, mode 0 -> lines >= 2 output 16'h0000 at cols 10 and 11 only (Gx = 1020); lines 0-1 all 16'hFFFF.
REQ-030 SHALL pass: same stimulus as REQ-029 in mode 2 -> 16'hFFFF at cols 10-11 (saturated) and 16'h0000 elsewhere; in mode 3 -> 16'hF800 at cols 10-11 and the input pixel elsewhere.
REQ-031 SHALL pass: cfg_threshold changed 128 -> 255 mid-frame -> current frame still uses 128; next frame uses 255.
REQ-032 SHALL pass: rst_n pulsed low on line 5 -> all post_* = 0 during reset; the next two lines after release output non-edge.
REQ-033 SHALL pass: a line of H_MAX+4 pixels -> last 4 outputs non-edge and the following line's window data is uncorrupted.
